// File: rtl/mmio_servo_responder.sv
// Memory-mapped responder for an 8-register I/O window that drives four servo PWM channels.
// Pulse widths go through shadow registers that only reload at a frame start.
module mmio_servo_responder #(
    parameter int unsigned     WIDTH        = 16,
    parameter logic [WIDTH-1:0] BASE         = 16'hD000,
    parameter logic [WIDTH-1:0] PULSE_RST    = 16'd1500,
    parameter logic [WIDTH-1:0] PERIOD_RST   = 16'd20000,
    parameter logic [WIDTH-1:0] PRESCALE_RST = 16'd49
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] address_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             we_i,
    input  logic             re_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rvalid_o,
    output logic [3:0]       pwm_out_o
);

    localparam int unsigned NumCh = 4;

    logic [WIDTH-1:0] offs_full;
    logic [2:0]       offset;
    logic             hit, wr, rd;
    logic             enable, tick, frame_start;
    logic [WIDTH-1:0] period_eff;

    logic [4:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] pulse_q [NumCh];
    logic [WIDTH-1:0] pulse_d [NumCh];
    logic [WIDTH-1:0] sh_q [NumCh];
    logic [WIDTH-1:0] sh_d [NumCh];
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] prescale_q, prescale_d;
    logic [WIDTH-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic [7:0]       fcount_q, fcount_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [3:0]       pwm_q, pwm_d;

    // Unsigned wrap-around makes addresses below BASE miss as well.
    assign offs_full   = address_i - BASE;
    assign hit         = offs_full < WIDTH'(8);
    assign offset      = offs_full[2:0];
    assign wr          = hit & we_i;
    assign rd          = hit & re_i & ~we_i;

    assign enable      = ctrl_q[0];
    assign period_eff  = (period_q == '0) ? WIDTH'(1) : period_q;
    // >= keeps the prescaler from running off if PRESCALE is lowered below the count.
    assign tick        = enable && (pre_q >= prescale_q);
    assign frame_start = tick && (cnt_q >= period_eff - WIDTH'(1));

    always_comb begin
        ctrl_d     = ctrl_q;
        pulse_d    = pulse_q;
        sh_d       = sh_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        pre_d      = pre_q;
        cnt_d      = cnt_q;
        flag_d     = flag_q;
        fcount_d   = fcount_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        pwm_d      = '0;

        if (!enable) begin
            pre_d = '0;
            cnt_d = '0;
            sh_d  = pulse_q;
        end else begin
            pre_d = tick ? '0 : pre_q + WIDTH'(1);
            if (tick) begin
                cnt_d = frame_start ? '0 : cnt_q + WIDTH'(1);
            end
            // Old PULSE values are captured, so a same-edge write waits a frame.
            if (frame_start) begin
                sh_d = pulse_q;
            end
        end

        for (int n = 0; n < NumCh; n++) begin
            pwm_d[n] = enable & ctrl_q[n+1] & (cnt_q < sh_q[n]);
        end

        if (wr) begin
            unique case (offset)
                3'd0: ctrl_d     = wdata_i[4:0];
                3'd1: pulse_d[0] = wdata_i;
                3'd2: pulse_d[1] = wdata_i;
                3'd3: pulse_d[2] = wdata_i;
                3'd4: pulse_d[3] = wdata_i;
                3'd5: period_d   = wdata_i;
                3'd6: prescale_d = wdata_i;
                3'd7: if (wdata_i[0]) flag_d = 1'b0;
            endcase
        end

        if (frame_start) begin
            flag_d   = 1'b1;
            fcount_d = fcount_q + 8'd1;
        end

        if (rd) begin
            rvalid_d = 1'b1;
            unique case (offset)
                3'd0: rdata_d = WIDTH'(ctrl_q);
                3'd1: rdata_d = pulse_q[0];
                3'd2: rdata_d = pulse_q[1];
                3'd3: rdata_d = pulse_q[2];
                3'd4: rdata_d = pulse_q[3];
                3'd5: rdata_d = period_q;
                3'd6: rdata_d = prescale_q;
                3'd7: rdata_d = WIDTH'({fcount_q, 7'd0, flag_q});
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q     <= '0;
            period_q   <= PERIOD_RST;
            prescale_q <= PRESCALE_RST;
            pre_q      <= '0;
            cnt_q      <= '0;
            flag_q     <= 1'b0;
            fcount_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            pwm_q      <= '0;
            for (int n = 0; n < NumCh; n++) begin
                pulse_q[n] <= PULSE_RST;
                sh_q[n]    <= PULSE_RST;
            end
        end else begin
            ctrl_q     <= ctrl_d;
            pulse_q    <= pulse_d;
            sh_q       <= sh_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            flag_q     <= flag_d;
            fcount_q   <= fcount_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            pwm_q      <= pwm_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign rvalid_o  = rvalid_q;
    assign pwm_out_o = pwm_q;

endmodule
